// File: rtl/tx_prbs_word_gen_pkg.sv
// tx_prbs_word_gen_pkg: shared modes, FSM states, default widths and counter helper for the PRBS generator
package tx_prbs_pack;
   localparam int N_PRBS_DEF = 32;
   localparam int N_WAYS_DEF = 16;
   localparam int CNT_W = 32;
   typedef enum logic [1:0] {MODE_LOAD = 2'd0, MODE_RUN = 2'd1, MODE_PAUSE = 2'd2, MODE_PAUSE_RSV = 2'd3} mode_t;
   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_PAUSE} fsm_t;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && v != '1) ? v + CNT_W'(1) : v;
   endfunction
endpackage

// File: rtl/tx_prbs_word_gen_step.sv
// prbs_par_step: n_ways unrolled serial LFSR steps producing one word and the advanced state
module prbs_par_step #(
   parameter int n_prbs = 32,
   parameter int n_ways = 16
) (
   input  logic [n_prbs-1:0] state,
   input  logic [n_prbs-1:0] eqn,
   output logic [n_ways-1:0] word,
   output logic [n_prbs-1:0] next_state
);
   logic [n_prbs-1:0] s;
   always_comb begin
      s = state;
      word = '0;
      for (int i = 0; i < n_ways; i++) begin
         word[i] = ^(s & eqn);
         s = {s[n_prbs-2:0], word[i]};
      end
      next_state = s;
   end
endmodule

// File: rtl/tx_prbs_word_gen.sv
// tx_prbs_word_gen: handshaked parallel PRBS word source with periodic bit-0 error injection
module tx_prbs_word_gen
   import tx_prbs_pack::*;
#(
   parameter int n_prbs = N_PRBS_DEF,
   parameter int n_ways = N_WAYS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic [n_prbs-1:0] prbs_eqn,
   input  logic [n_prbs-1:0] prbs_init,
   input  logic [15:0]       inj_err_period,
   output logic [n_ways-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  word_cnt,
   output logic [CNT_W-1:0]  err_cnt
);
   fsm_t st;
   logic [n_prbs-1:0] state, step_state;
   logic [n_ways-1:0] step_word;
   logic [15:0] inj_cnt;
   logic [16:0] inj_nxt;
   logic out_err, run, hs, gen, wrap;
   prbs_par_step #(.n_prbs(n_prbs), .n_ways(n_ways)) u_step (
      .state(state),
      .eqn(prbs_eqn),
      .word(step_word),
      .next_state(step_state)
   );
   assign run = mode == MODE_RUN;
   assign hs = st == ST_RUN && out_valid && out_ready;
   assign gen = (st == ST_FILL && run) || hs;
   assign inj_nxt = {1'b0, inj_cnt} + 17'd1;
   assign wrap = |inj_err_period && inj_nxt >= {1'b0, inj_err_period};
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= ST_IDLE;
         state <= n_prbs'(1);
         out_data <= '0;
         out_valid <= 1'b0;
         word_cnt <= '0;
         err_cnt <= '0;
         inj_cnt <= '0;
         out_err <= 1'b0;
      end else begin
         word_cnt <= sat_inc(word_cnt, hs);
         err_cnt <= sat_inc(err_cnt, hs && out_err);
         if (mode == MODE_LOAD) begin
            st <= ST_IDLE;
            state <= |prbs_init ? prbs_init : n_prbs'(1);
            out_data <= '0;
            out_valid <= 1'b0;
            inj_cnt <= '0;
            out_err <= 1'b0;
            // a handshake in the LOAD cycle is still counted; the next LOAD cycle clears it
            if (!hs) begin
               word_cnt <= '0;
               err_cnt <= '0;
            end
         end else begin
            if (gen) begin
               state <= step_state;
               out_data <= step_word ^ n_ways'(wrap);
               out_err <= wrap;
               inj_cnt <= wrap ? '0 : inj_nxt[15:0];
            end
            out_valid <= run && st != ST_IDLE;
            st <= st == ST_IDLE ? (run ? ST_FILL : ST_IDLE) :
                  st == ST_FILL ? (run ? ST_RUN : ST_IDLE) :
                  run ? ST_RUN : ST_PAUSE;
         end
      end
   end
endmodule

// File: tb/tb_tx_prbs_word_gen.sv
// tb_tx_prbs_word_gen: directed checks of the PRBS word generator against a serial bit-level model
module tb_tx_prbs_word_gen;
   localparam logic [31:0] EQN = 32'h0008_0001;
   logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0, out_valid;
   logic [1:0] mode = 2'd0;
   logic [31:0] prbs_eqn = EQN, prbs_init = 32'd1, word_cnt, err_cnt, m_state;
   logic [15:0] inj_err_period = 16'd0, out_data;
   int n_tests = 0, n_fail = 0, m_idx = 0;
   always #5 clk = ~clk;
   tx_prbs_word_gen #(.n_prbs(32), .n_ways(16)) dut (
      .clk(clk),
      .rst(rst),
      .mode(mode),
      .prbs_eqn(prbs_eqn),
      .prbs_init(prbs_init),
      .inj_err_period(inj_err_period),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .word_cnt(word_cnt),
      .err_cnt(err_cnt)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic next_word(output logic [15:0] w);
      logic b;
      for (int i = 0; i < 16; i++) begin
         b = ^(m_state & prbs_eqn);
         w[i] = b;
         m_state = {m_state[30:0], b};
      end
      m_idx++;
      if (inj_err_period != 0 && m_idx % int'(inj_err_period) == 0) w[0] = ~w[0];
   endtask
   task automatic start(input logic [31:0] seed, input logic [15:0] per);
      mode = 2'd0;
      prbs_init = seed;
      inj_err_period = per;
      out_ready = 1'b0;
      step();
      check("load_valid", 32'(out_valid), 32'd0);
      check("load_wcnt", word_cnt, 32'd0);
      mode = 2'd1;
      step();
      check("fill_valid", 32'(out_valid), 32'd0);
      step();
      check("first_valid", 32'(out_valid), 32'd1);
      m_state = (seed == 0) ? 32'd1 : seed;
      m_idx = 0;
   endtask
   task automatic accept(input int n, input int stall_after, input int stall_len,
                         input int pause_after, input int pause_len);
      logic [15:0] w;
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         next_word(w);
         check("valid", 32'(out_valid), 32'd1);
         check("data", 32'(out_data), 32'(w));
         if (i == stall_after) begin
            out_ready = 1'b0;
            for (int k = 0; k < stall_len; k++) begin
               step();
               check("stall_data", 32'(out_data), 32'(w));
               check("stall_valid", 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
         end
         if (i == pause_after) begin
            mode = 2'd2;
            for (int k = 0; k < pause_len; k++) begin
               step();
               check("pause_valid", 32'(out_valid), 32'd0);
            end
            mode = 2'd1;
         end
         step();
      end
      out_ready = 1'b0;
      step();
   endtask
   initial begin
      step();
      step();
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_wcnt", word_cnt, 32'd0);
      check("rst_ecnt", err_cnt, 32'd0);
      rst = 1'b0;
      start(32'd1, 16'd0);
      check("hand_w0", 32'(out_data), 32'h0000_FFFF);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("hand_w1", 32'(out_data), 32'h0000_5557);
      check("hand_wcnt", word_cnt, 32'd1);
      start(32'd1, 16'd0);
      accept(100, -1, 0, -1, 0);
      check("run_wcnt", word_cnt, 32'd100);
      check("run_ecnt", err_cnt, 32'd0);
      start(32'd1, 16'd0);
      accept(20, 3, 5, -1, 0);
      check("stall_wcnt", word_cnt, 32'd20);
      start(32'd1, 16'd4);
      accept(100, -1, 0, -1, 0);
      check("inj4_wcnt", word_cnt, 32'd100);
      check("inj4_ecnt", err_cnt, 32'd25);
      start(32'd1, 16'd1);
      accept(10, -1, 0, -1, 0);
      check("inj1_ecnt", err_cnt, 32'd10);
      start(32'd0, 16'd0);
      accept(20, -1, 0, -1, 0);
      check("seed0_wcnt", word_cnt, 32'd20);
      start(32'd1, 16'd0);
      accept(30, -1, 0, 9, 7);
      check("pause_wcnt", word_cnt, 32'd30);
      start(32'd1, 16'd0);
      accept(50, -1, 0, -1, 0);
      check("pre_rst_wcnt", word_cnt, 32'd50);
      rst = 1'b1;
      out_ready = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_wcnt", word_cnt, 32'd0);
      check("mid_rst_ecnt", err_cnt, 32'd0);
      step();
      check("mid_rst_fill", 32'(out_valid), 32'd0);
      step();
      m_state = 32'd1;
      m_idx = 0;
      accept(5, -1, 0, -1, 0);
      check("post_rst_wcnt", word_cnt, 32'd5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/tx_prbs_word_gen.md
# tx_prbs_word_gen

Parallel PRBS word generator: the transmit-side counterpart of the digital core's PRBS checker. Each accepted handshake produces one `n_ways`-bit word of a programmable-polynomial LFSR sequence, with optional periodic single-bit error injection. It sits in the TX/loopback datapath, feeding the checker or an emulated channel. It is configured through the same JTAG register style as the checker: equation, seed and mode.

## Interface
Parameters:
- `n_prbs`, 32: LFSR state width; also the width of the equation and seed inputs.
- `n_ways`, 16: bits per output word (channel width).

Ports:
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mode` input 2: 0 = LOAD, 1 = RUN, 2 = PAUSE, 3 = PAUSE (reserved).
- `prbs_eqn` input `n_prbs`: tap mask.
- `prbs_init` input `n_prbs`: seed; all-zero seed is replaced by 1.
- `inj_err_period` input 16: 0 = no injection; N = corrupt every Nth emitted word.
- `out_data` output `n_ways`: word; bit 0 is earliest in time.
- `out_valid` output 1: `out_data` holds a word.
- `out_ready` input 1: consumer accepts the word this cycle.
- `word_cnt` output 32: words accepted; saturates at 2^32-1.
- `err_cnt` output 32: injected-error words accepted; saturates.

## Operation
- Serial step: `b = ^(state & prbs_eqn)`; `state <= {state[n_prbs-2:0], b}`; emitted bit = `b`. One word = `n_ways` consecutive steps. `out_data[i]` = bit of step i.
- States:
  - IDLE (reset; entered whenever mode=LOAD): `state <= (prbs_init==0) ? 1 : prbs_init`. Output register cleared, `out_valid=0`, both counters cleared, injection counter cleared.
  - FILL (mode=RUN, `out_valid=0`): output register <= word(state), `state` <= state after `n_ways` steps, `out_valid <= 1`.
  - RUN (mode=RUN, `out_valid=1`): on `out_ready`, `word_cnt++`, `err_cnt++` if the word was corrupted, and the next word is loaded in the same edge (no bubble). Without `out_ready`, `out_data` holds stable.
  - PAUSE (mode=2/3): `out_valid <= 0`. The held word and `state` are frozen; counters hold. Returning to RUN re-presents the held word one cycle later, so no bits are lost or duplicated.
- Injection: an injection counter counts generated words modulo `inj_err_period`. The word at which it wraps (the Nth, 2Nth, ...) has `out_data[0]` inverted. The inversion is applied on the output only; LFSR state is never corrupted. Changing the period takes effect at the next generated word. Period 1 corrupts every word.
- Sticky-zero protection: if `prbs_eqn` = 0 the output is constant 0. This is legal; no special handling.

## Timing
- Reset values: `out_data=0`, `out_valid=0`, `word_cnt=0`, `err_cnt=0`, internal state = 1, FSM = IDLE.
- `rst` asserted mid-run: all of the above apply at the next edge, regardless of `out_ready`. This is the same effect as LOAD, except LOAD uses `prbs_init`.
- Latency: `mode` sampled as RUN at edge k → `out_valid=1` after edge k+1 (one FILL cycle).
- Throughput: one word per cycle while `out_ready=1`.
- Mode change to PAUSE or LOAD in the same cycle as a handshake: the handshake completes (counted) first, then the new mode applies. For PAUSE, the next word is generated but not presented.
- Counters update on the edge of the handshake; visible the following cycle.
- Combinational depth: `n_ways` XOR-reduction stages; must close at `clk_adc` rate for the default parameters.

## Structure
- Package `tx_prbs_pack`: `mode` enum (LOAD, RUN, PAUSE), FSM state enum, `N_PRBS_DEF=32`, `N_WAYS_DEF=16`, counter width 32.
- Sub-module `prbs_par_step`: purely combinational. Inputs are `state` and `eqn`; outputs are the `n_ways`-bit word and the advanced state (unrolled loop). Reusable by the checker.
- Top-level holds the FSM, output register, injection counter and saturating counters.

## Test plan
- Seed 1, taps 1 and 20, `out_ready=1`, 100 words → every word matches a serial bit-level model. `word_cnt`=100, `err_cnt`=0.
- Same seed, `out_ready` low for 5 cycles after word 3 → `out_data` stable for 5 cycles. Concatenated accepted stream is identical to the unstalled run.
- `inj_err_period`=4, 100 words → words 4, 8, … 100 differ from the model only in bit 0. `err_cnt`=25. Period=1 → all words have bit 0 flipped.
- `prbs_init`=0 → output identical to the `prbs_init`=1 run.
- RUN 10 words, PAUSE 7 cycles, RUN → `out_valid` low during the pause. Accepted stream is contiguous with no gap or repeat versus the model.
- `rst` pulsed after 50 words with `out_ready=1` → next cycle `out_valid`=0, both counters 0. RUN then restarts the sequence from seed 1.
